// File: rtl/data_mem_arbiter_pkg.sv
// Shared types and constants for the two-master data-memory arbiter.
package data_mem_arbiter_pkg;

    localparam int unsigned ARB_DATA_W  = 32;
    localparam int unsigned ARB_MAX_OUT = 2;
    localparam int unsigned ARB_CNT_W   = $clog2(ARB_MAX_OUT) + 1;

    typedef logic [0:0] arb_id_t;

    localparam arb_id_t ARB_MASTER_IF  = 1'b0;
    localparam arb_id_t ARB_MASTER_LSU = 1'b1;

    typedef enum logic {
        LOCK_IDLE = 1'b0,
        LOCK_HELD = 1'b1
    } lock_state_e;

    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/data_mem_arbiter_id_fifo.sv
// In-order FIFO of issuing-master IDs for granted, not yet answered transactions.
module arb_id_fifo
    import data_mem_arbiter_pkg::*;
#(
    parameter  int unsigned DEPTH = ARB_MAX_OUT,
    localparam int unsigned CNT_W = cnt_width(DEPTH),
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  arb_id_t          data_i,
    output arb_id_t          head_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o
);

    arb_id_t          r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_push;
    logic             w_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full_o  = (r_count == CNT_W'(DEPTH));
    assign empty_o = (r_count == '0);
    assign count_o = r_count;
    assign head_o  = r_mem[r_rd_ptr];
    assign w_push  = push_i & ~full_o;
    assign w_pop   = pop_i & ~empty_o;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
            if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: entries are only read while the count says they are valid.
    always_ff @(posedge clk_i) begin
        if (w_push) r_mem[r_wr_ptr] <= data_i;
    end

endmodule

// File: rtl/data_mem_arbiter.sv
// Round-robin arbiter sharing one OBI-style data-memory port between fetch (0) and LSU (1).
module data_mem_arbiter
    import data_mem_arbiter_pkg::*;
#(
    parameter  int unsigned DATA_WIDTH      = ARB_DATA_W,
    parameter  int unsigned MAX_OUTSTANDING = ARB_MAX_OUT,
    localparam int unsigned CNT_W           = cnt_width(MAX_OUTSTANDING)
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [1:0]                 m_req_i,
    output logic [1:0]                 m_gnt_o,
    output logic [1:0]                 m_rvalid_o,
    input  logic [1:0][DATA_WIDTH-1:0] m_addr_i,
    input  logic [1:0]                 m_we_i,
    input  logic [1:0][3:0]            m_be_i,
    input  logic [1:0][DATA_WIDTH-1:0] m_wdata_i,
    output logic [DATA_WIDTH-1:0]      m_rdata_o,
    output logic                       data_req_o,
    input  logic                       data_gnt_i,
    input  logic                       data_rvalid_i,
    output logic [DATA_WIDTH-1:0]      data_addr_o,
    output logic                       data_we_o,
    output logic [3:0]                 data_be_o,
    output logic [DATA_WIDTH-1:0]      data_wdata_o,
    input  logic [DATA_WIDTH-1:0]      data_rdata_i,
    output logic                       err_o
);

    lock_state_e      r_lock_st;
    lock_state_e      w_lock_st_nxt;
    arb_id_t          r_lock_id;
    arb_id_t          w_lock_id_nxt;
    arb_id_t          r_prio;
    arb_id_t          w_prio_nxt;
    logic             r_err;
    logic             w_err_nxt;
    arb_id_t          w_sel;
    arb_id_t          w_head;
    logic             w_eligible;
    logic             w_hs;
    logic             w_pop;
    logic             w_full;
    logic             w_empty;
    logic [CNT_W-1:0] w_count;

    assign err_o     = r_err;
    assign m_rdata_o = data_rdata_i;
    assign w_eligible = (w_count < CNT_W'(MAX_OUTSTANDING)) & ~w_full;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_lock_st <= LOCK_IDLE;
            r_lock_id <= ARB_MASTER_IF;
            r_prio    <= ARB_MASTER_IF;
            r_err     <= 1'b0;
        end else begin
            r_lock_st <= w_lock_st_nxt;
            r_lock_id <= w_lock_id_nxt;
            r_prio    <= w_prio_nxt;
            r_err     <= w_err_nxt;
        end
    end

    // Selection, memory-side request, grants, routing and next-state logic.
    always_comb begin
        w_sel         = r_prio;
        data_req_o    = 1'b0;
        w_hs          = 1'b0;
        w_pop         = 1'b0;
        m_gnt_o       = '0;
        m_rvalid_o    = '0;
        w_lock_st_nxt = LOCK_IDLE;
        w_lock_id_nxt = r_lock_id;
        w_prio_nxt    = r_prio;
        w_err_nxt     = r_err;

        if (r_lock_st == LOCK_HELD) begin
            w_sel = r_lock_id;
        end else begin
            case (m_req_i)
                2'b01:   w_sel = ARB_MASTER_IF;
                2'b10:   w_sel = ARB_MASTER_LSU;
                default: w_sel = r_prio;
            endcase
        end

        data_req_o = m_req_i[w_sel] & w_eligible;
        // A grant seen during reset is not a transaction: the memory is reset with us.
        w_hs       = data_req_o & data_gnt_i & ~rst_i;
        m_gnt_o[w_sel] = w_hs;

        w_pop = data_rvalid_i & ~w_empty;
        m_rvalid_o[w_head] = w_pop;

        if (data_req_o && !data_gnt_i) begin
            w_lock_st_nxt = LOCK_HELD;
            w_lock_id_nxt = w_sel;
        end
        if (w_hs) w_prio_nxt = ~w_sel;
        if (data_rvalid_i && w_empty) w_err_nxt = 1'b1;
    end

    always_comb begin
        data_addr_o  = m_addr_i[w_sel];
        data_we_o    = m_we_i[w_sel];
        data_be_o    = m_be_i[w_sel];
        data_wdata_o = m_wdata_i[w_sel];
    end

    arb_id_fifo #(
        .DEPTH(MAX_OUTSTANDING)
    ) u_id_fifo (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .push_i (w_hs),
        .pop_i  (w_pop),
        .data_i (w_sel),
        .head_o (w_head),
        .full_o (w_full),
        .empty_o(w_empty),
        .count_o(w_count)
    );

endmodule

// File: doc/data_mem_arbiter.md
Name: data_mem_arbiter

Overview:
- Shares the single data-memory req/gnt/rvalid port between two requesters: master 0 = instruction fetch, master 1 = the MEM-stage load/store unit.
- Round-robin arbitration; address phase held stable until granted.
- Tracks in-order outstanding transactions and routes each rvalid/rdata back to the master that issued it.
- Sits between the core's fetch and MEM stages and the memory interface.

Parameters:
- DATA_WIDTH, 32, address/data width; taken from riscv_cpu_pkg.
- MAX_OUTSTANDING, 2, maximum granted-but-unanswered transactions; power of two, ≥1.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset; synchronous, active-high
- m_req_i  in  [1:0]  per-master request
- m_gnt_o  out  [1:0]  per-master grant
- m_rvalid_o  out  [1:0]  per-master response valid
- m_addr_i  in  [1:0][DATA_WIDTH-1:0]  per-master address
- m_we_i  in  [1:0]  per-master write enable
- m_be_i  in  [1:0][3:0]  per-master byte enables
- m_wdata_i  in  [1:0][DATA_WIDTH-1:0]  per-master write data
- m_rdata_o  out  DATA_WIDTH  response data, broadcast to both masters
- data_req_o  out  1  memory request
- data_gnt_i  in  1  memory grant
- data_rvalid_i  in  1  memory response valid
- data_addr_o  out  DATA_WIDTH  memory address
- data_we_o  out  1  memory write enable
- data_be_o  out  4  memory byte enables
- data_wdata_o  out  DATA_WIDTH  memory write data
- data_rdata_i  in  DATA_WIDTH  memory read data
- err_o  out  1  sticky protocol error (rvalid with no outstanding transaction)

Behaviour:
- Reset (rst_i high at a clock edge):
  - priority pointer = master 0; lock cleared; ID FIFO empty; count = 0; err_o = 0.
  - Outputs after reset: data_req_o = 0 while no m_req_i; m_gnt_o = 0; m_rvalid_o = 0.
  - Reset mid-operation drops all outstanding state; the memory shares the same reset.
- Eligibility: the arbiter may issue only when count < MAX_OUTSTANDING. When full, no new request issues, even if a pop happens in the same cycle; there is no combinational path from data_rvalid_i to data_req_o.
- Selection, when not locked:
  - One master requesting: select it.
  - Both requesting: select the master indicated by the priority pointer.
- data_req_o = selected master's m_req_i AND eligible.
- data_addr/we/be/wdata_o are muxed combinationally from the selected master.
- m_gnt_o[sel] = data_req_o & data_gnt_i; the other grant bit is 0. Zero-cycle grant is allowed.
- Lock: if data_req_o = 1 and data_gnt_i = 0, register lock = 1 and lock_id = sel.
  - While locked, the selection is forced to lock_id regardless of the pointer or the other master.
  - Lock clears on the handshake cycle.
  - Masters must hold req and payload stable until gnt (OBI rule). If the locked master drops req anyway, data_req_o falls and the lock clears.
- Pointer update on a handshake with master k: pointer = ~k, so the other master gets priority next.
- ID FIFO, depth MAX_OUTSTANDING, 1-bit entries:
  - Push sel on handshake; pop on data_rvalid_i; count tracks occupancy.
  - Push and pop in the same cycle: count unchanged, pointers both advance with wrap-around modulo depth.
- Response routing: m_rvalid_o[head_id] = data_rvalid_i, other bit 0. m_rdata_o = data_rdata_i (pass-through, no register). Earliest response is the cycle after grant. Responses are in order.
- data_rvalid_i with count = 0: no pop, m_rvalid_o = 0, err_o set to 1 until reset.
- Latency: 0 added cycles on both request and response paths.

Decomposition:
- riscv_cpu_pkg additions:
  - arb_id_t (1-bit master index)
  - constants ARB_MASTER_IF = 0, ARB_MASTER_LSU = 1
  - localparam ARB_CNT_W = $clog2(MAX_OUTSTANDING) + 1
- Sub-module arb_id_fifo: synchronous FIFO of arb_id_t with push/pop/full/empty/head and count output. Same clock, same sync active-high reset.

Test Plan:
- Master 1 alone reads 0x100 with data_gnt_i = 1 the same cycle, data_rvalid_i next cycle with rdata 0xDEADBEEF → m_gnt_o = 2'b10 in cycle 0; m_rvalid_o = 2'b10 and m_rdata_o = 0xDEADBEEF in cycle 1; err_o = 0.
- Both masters request continuously, gnt always 1, rvalid 1 cycle later → grants alternate 01, 10, 01, 10 starting with master 0 after reset; each rvalid is routed to the matching master.
- Master 1 requests with gnt = 0 for 3 cycles; master 0 asserts req in cycle 1 while the pointer favours 0 → data_addr_o stays at master 1's address and m_gnt_o[0] = 0 until master 1 is granted; master 0 is granted on the next cycle.
- MAX_OUTSTANDING = 2, gnt = 1, rvalid withheld → two grants, then data_req_o = 0 while both masters request. One rvalid → head master receives m_rvalid_o; data_req_o reasserts the following cycle.
- data_rvalid_i pulse after reset with no request → m_rvalid_o = 00, err_o = 1 and it stays 1; rst_i pulse → err_o = 0.
- rst_i asserted while 1 transaction is outstanding and a second is locked → next cycle: data_req_o follows only current m_req_i, count = 0, pointer = master 0, m_gnt_o = 0 during the reset cycle.
